// File: rtl/mux8way16_if.sv
// mux8way16_if: request/word/ack bundle and valid/ready output channel of the arbiter.
interface mux8way16_if #(parameter int WIDTH = 16);
    logic [7:0]       req;
    logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
    logic [7:0]       ack;
    logic [2:0]       grant_sel;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    modport master (input req, a, b, c, d, e, f, g, h, out_ready,
                    output ack, grant_sel, out, out_valid, busy);
    modport slave  (output req, a, b, c, d, e, f, g, h, out_ready,
                    input ack, grant_sel, out, out_valid, busy);
endinterface

// File: rtl/mux8way16_arbiter.sv
// mux8way16_arbiter: round-robin pick of eight word sources into one valid/ready holding register.
module mux8way16_arbiter #(parameter int WIDTH = 16) (
    input logic         clk,
    input logic         reset,
    mux8way16_if.master bus
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t           state, state_nx;
    logic [2:0]       ptr, off, win;
    logic [7:0]       ereq, rot;
    logic [15:0]      rot2;
    logic [WIDTH-1:0] word;
    logic             any, hs, cap;
    // a source acked this cycle is masked so it cannot win twice for one word
    assign ereq = bus.req & ~bus.ack;
    assign any  = |ereq;
    assign rot2 = {ereq, ereq} >> ptr;
    assign rot  = rot2[7:0];
    always_comb begin
        off = '0;
        for (int i = 7; i >= 0; i--)
            if (rot[i]) off = 3'(i);
    end
    assign win = ptr + off;
    always_comb begin
        word = bus.a;
        case (win)
            3'd1: word = bus.b;
            3'd2: word = bus.c;
            3'd3: word = bus.d;
            3'd4: word = bus.e;
            3'd5: word = bus.f;
            3'd6: word = bus.g;
            3'd7: word = bus.h;
            default: word = bus.a;
        endcase
    end
    assign hs  = (state == HOLD) && bus.out_ready;
    assign cap = ((state == IDLE) || hs) && any;
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (any ? HOLD : IDLE) : ((hs && !any) ? IDLE : HOLD);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            bus.ack       <= '0;
            bus.out       <= '0;
            bus.grant_sel <= '0;
        end else begin
            state   <= state_nx;
            bus.ack <= cap ? (8'b1 << win) : 8'b0;
            if (cap) begin
                bus.out       <= word;
                bus.grant_sel <= win;
                ptr           <= win + 3'd1;
            end
        end
    end
    assign bus.out_valid = (state == HOLD);
    assign bus.busy      = (state == HOLD);
endmodule

// File: tb/tb_mux8way16_arbiter.sv
// tb_mux8way16_arbiter: directed stimulus with a queue of expected captures drained by an ack-driven monitor.
module tb_mux8way16_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [18:0] q[$];
    mux8way16_if #(.WIDTH(16)) bus ();
    mux8way16_arbiter #(.WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [2:0] gs, input logic [15:0] w);
        q.push_back({gs, w});
    endtask
    // every ack pulse marks exactly one capture; compare it with the next expected word
    always @(negedge clk) begin
        if (bus.ack != 8'h00) begin
            if (q.size() == 0) begin
                chk("unexpected_capture", {13'd0, bus.grant_sel, bus.out}, 32'hFFFF_FFFF);
            end else begin
                logic [18:0] e;
                e = q.pop_front();
                chk("capture_grant_out", {13'd0, bus.grant_sel, bus.out}, {13'd0, e});
                chk("capture_ack", {24'd0, bus.ack}, {24'd0, 8'b1 << e[18:16]});
                chk("capture_valid", {31'd0, bus.out_valid}, 32'd1);
            end
        end
    end
    initial begin
        reset = 1'b1;
        bus.req = '0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;
        bus.e = '0; bus.f = '0; bus.g = '0; bus.h = '0;
        step(); step();
        @(negedge clk);
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out", {16'd0, bus.out}, 32'd0);
        chk("rst_ack", {24'd0, bus.ack}, 32'd0);
        chk("rst_grant", {29'd0, bus.grant_sel}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;
        // single requester
        bus.c = 16'hBEEF; bus.req = 8'h04; bus.out_ready = 1'b1;
        push(3'd2, 16'hBEEF);
        step();
        @(negedge clk);
        chk("single_ack", {24'd0, bus.ack}, 32'h04);
        chk("single_busy", {31'd0, bus.busy}, 32'd1);
        bus.req = 8'h00;
        step();
        @(negedge clk);
        chk("single_drain_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("single_drain_busy", {31'd0, bus.busy}, 32'd0);
        chk("single_keep_out", {16'd0, bus.out}, 32'hBEEF);
        chk("single_keep_grant", {29'd0, bus.grant_sel}, 32'd2);
        chk("single_ack_clear", {24'd0, bus.ack}, 32'd0);
        // all eight from ptr=3
        bus.a = 16'h0; bus.b = 16'h1; bus.c = 16'h2; bus.d = 16'h3;
        bus.e = 16'h4; bus.f = 16'h5; bus.g = 16'h6; bus.h = 16'h7;
        bus.req = 8'hFF;
        for (int i = 0; i < 9; i++) push(3'((i + 3) % 8), 16'((i + 3) % 8));
        repeat (9) step();
        bus.req = 8'h00;
        step();
        @(negedge clk);
        chk("all8_idle", {31'd0, bus.out_valid}, 32'd0);
        // reset while holding an undelivered word
        bus.out_ready = 1'b0; bus.req = 8'hFF;
        push(3'd4, 16'h4);
        step();
        @(negedge clk);
        chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.req = 8'h00; reset = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_out", {16'd0, bus.out}, 32'd0);
        chk("midrst_ack", {24'd0, bus.ack}, 32'd0);
        chk("midrst_grant", {29'd0, bus.grant_sel}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0; bus.out_ready = 1'b1; bus.req = 8'hFF;
        for (int i = 0; i < 9; i++) push(3'(i % 8), 16'(i % 8));
        repeat (9) step();
        bus.req = 8'h00;
        step();
        // backpressure from ptr=0
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.a = 16'hAAAA; bus.h = 16'h7777; bus.out_ready = 1'b0; bus.req = 8'h81;
        push(3'd0, 16'hAAAA);
        step();
        bus.req = 8'h80;
        @(negedge clk);
        chk("bp_first_ack", {24'd0, bus.ack}, 32'h01);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk("bp_hold_out", {16'd0, bus.out}, 32'hAAAA);
            chk("bp_hold_grant", {29'd0, bus.grant_sel}, 32'd0);
            chk("bp_no_ack", {24'd0, bus.ack}, 32'd0);
        end
        bus.out_ready = 1'b1;
        push(3'd7, 16'h7777);
        step();
        bus.req = 8'h00;
        step();
        @(negedge clk);
        chk("bp_idle", {31'd0, bus.out_valid}, 32'd0);
        // wrap from ptr=7 with 6 re-requesting
        bus.a = 16'h0A0A; bus.g = 16'h0606; bus.req = 8'h40;
        push(3'd6, 16'h0606); push(3'd0, 16'h0A0A); push(3'd6, 16'h0606);
        step();
        bus.req = 8'h41;
        step(); step();
        bus.req = 8'h00;
        step();
        // self-mask: source 5 keeps req high through its ack cycle
        bus.f = 16'h5555; bus.req = 8'h20;
        push(3'd5, 16'h5555);
        step();
        bus.f = 16'h5556;
        step();
        @(negedge clk);
        chk("mask_no_recapture", {31'd0, bus.out_valid}, 32'd0);
        chk("mask_no_ack", {24'd0, bus.ack}, 32'd0);
        chk("mask_out_kept", {16'd0, bus.out}, 32'h5555);
        push(3'd5, 16'h5556);
        step();
        bus.req = 8'h00;
        step();
        repeat (3) step();
        chk("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux8way16_arbiter.md
# mux8way16_arbiter

Round-robin arbiter that shares one 16-bit, 8-to-1 word path among eight requesters. Each cycle it picks one pending requester in rotating priority, drives that requester's select code into the 8-way mux, and registers the selected word into a single output holding register. A valid/ready handshake drains the register to the downstream consumer. It sits between eight independent word sources and one consumer, for example a shared memory write port or an output channel.

## Interface
- WIDTH, 16, data word width for each source and for `out`.
- clk  in  1  single clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- req  in  8  bit i is high when source i has a word pending.
- a, b, c, d, e, f, g, h  in  WIDTH each  source words 0..7; source i's word must stay stable while `req[i]` is high.
- ack  out  8  one-hot, one-cycle pulse: source i's word has been captured.
- grant_sel  out  3  index of the source whose word is in `out`; also the mux select code.
- out  out  WIDTH  registered output word.
- out_valid  out  1  `out` holds an undelivered word.
- out_ready  in  1  consumer accepts `out` on any edge where `out_valid` and `out_ready` are both high.
- busy  out  1  high when the FSM is in HOLD.

## Operation
- Internal state:
  - `ptr[2:0]` is the highest-priority index.
  - FSM has two states, IDLE and HOLD.
- Effective requests: `ereq = req & ~ack`. A source being acked in the current cycle cannot win again in that same cycle.
- Winner: the first set bit of `ereq`, scanning `ptr, ptr+1, …, 7, 0, …, ptr-1` (mod 8). Mux mapping is 0→a, 1→b, 2→c, 3→d, 4→e, 5→f, 6→g, 7→h.
- Capture event is one edge that does all of the following:
  - `out` ← selected word.
  - `grant_sel` ← winner.
  - `out_valid` ← 1.
  - `ack` ← one-hot(winner) for the next cycle only.
  - `ptr` ← winner+1 (mod 8; 7 wraps to 0).
- IDLE:
  - `out_valid` = 0 and `out_ready` is ignored.
  - If `ereq` ≠ 0, a capture event occurs and the FSM goes to HOLD.
  - Otherwise the FSM stays in IDLE.
- HOLD:
  - `out`, `grant_sel` and `out_valid` = 1 stay stable until the handshake.
  - On the handshake edge, if `ereq` ≠ 0, a capture event occurs and the FSM stays in HOLD. This gives back-to-back transfers.
  - On the handshake edge, if `ereq` = 0, `out_valid` ← 0 and the FSM goes to IDLE. `out` and `grant_sel` keep their last values.
  - Without a handshake, nothing is captured and `ptr` is unchanged, whatever `req` does.
- Source protocol: after seeing `ack[i]`, the source drops `req[i]` or presents its next word by the end of that ack cycle.
- Reset (including mid-transfer):
  - `out`=0, `out_valid`=0, `ack`=0, `grant_sel`=0, `ptr`=0, `busy`=0, FSM=IDLE.
  - A held undelivered word is discarded and no ack is issued for it.
  - `reset` has priority over every other event on the same edge.

## Timing
- Latency: `req[i]` high in cycle T while IDLE gives `out_valid`=1 and `ack[i]`=1 in cycle T+1.
- Throughput: one word per cycle while `out_ready` is held high and `ereq` ≠ 0 on every handshake edge.
- `ack` is registered, is never high for two consecutive cycles for the same capture, and has at most one bit set.
- `busy` equals `out_valid`.
- A request that rises in the same cycle as a handshake takes part in that cycle's arbitration.
- Fairness: a continuously asserted request is granted within 8 captures.
- `out_ready` may toggle arbitrarily. `out` must not change while `out_valid`=1 and `out_ready`=0.

## Test plan
- Reset then single requester: `req`=8'h04, `c`=16'hBEEF, `out_ready`=1. Expect `out`=16'hBEEF, `grant_sel`=2, `ack`=8'h04 one cycle after `req`. Then `out_valid`=0 after the handshake once `req` drops; `ptr`=3.
- All eight requesting continuously with `out_ready`=1 and distinct words a..h = 16'h0000..16'h0007. Expect grants 0,1,…,7,0 on consecutive cycles, `out` following the same values, and one ack per cycle.
- Backpressure: `req`=8'h81 with `out_ready`=0 for 5 cycles. Expect `out`=a held, `grant_sel`=0 and a single `ack` pulse. After `out_ready`=1, the next capture is source 7.
- Wrap and priority: `ptr`=7 (after a grant to 6) with `req`=8'h41. Expect a grant to 0 next, then `ptr`=1, then 6.
- Self-mask: source 5 alone keeps `req` high through its ack cycle with `out_ready`=1. Expect no second capture in the ack cycle. The next word is captured on the following handshake.
- Reset asserted in HOLD with `out_valid`=1. Next cycle expect `out_valid`=0, `out`=0, `ack`=0, `ptr`=0, and a fresh grant order starting from 0.
